// File: rtl/tt_uio_bus_arbiter_if.sv
// tt_uio_bus_arbiter_if: request/response and uio pad bundle
// shared between the user requesters (master) and the arbiter (slave).
interface tt_uio_bus_arbiter_if #(
    parameter int NREQ = 4
) ();
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              ena;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_dir;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_data;
    logic [7:0]        uio_in;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;
    logic [GW-1:0]     grant_id;
    logic              busy;

    modport master (
        output ena, req_valid, req_dir, req_data, req_last, uio_in,
        input  req_ready, rsp_valid, rsp_data, uio_out, uio_oe,
        input  grant_id, busy
    );

    modport slave (
        input  ena, req_valid, req_dir, req_data, req_last, uio_in,
        output req_ready, rsp_valid, rsp_data, uio_out, uio_oe,
        output grant_id, busy
    );
endinterface

// File: rtl/tt_uio_bus_arbiter.sv
// tt_uio_bus_arbiter: round-robin owner of the 8 uio pins with bounded
// hold time and output-enable turnaround on direction change.
module tt_uio_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int HOLD_MAX   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    tt_uio_bus_arbiter_if.slave        bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_OWN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_gnt;
    logic [GW-1:0]   r_ptr;
    logic            r_last_dir;
    logic [HW-1:0]   r_hold;
    logic [TW-1:0]   r_turn;
    logic [7:0]      r_uio_out;
    logic [7:0]      r_uio_oe;
    logic [NREQ-1:0] r_rsp_valid;
    logic [7:0]      r_rsp_data;

    logic [GW-1:0]   w_pick;
    logic            w_found;
    logic            w_gdir;
    logic            w_gvalid;
    logic            w_glast;
    logic [7:0]      w_gdata;
    logic            w_can;
    logic            w_hold_end;
    logic [NREQ-1:0] w_ready;

    assign w_gdir     = bus.req_dir[r_gnt];
    assign w_gvalid   = bus.req_valid[r_gnt];
    assign w_glast    = bus.req_last[r_gnt];
    assign w_gdata    = bus.req_data[{r_gnt, 3'b000} +: 8];
    assign w_hold_end = (r_hold == HW'(HOLD_MAX - 1));

    // a beat moves only while owning, enabled, and the owner keeps its direction
    assign w_can = (r_state == S_OWN) & bus.ena & w_gvalid
                 & (w_gdir == r_last_dir);

    // first valid requester after the round-robin pointer, wrapping
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && bus.req_valid[v_idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(v_idx);
            end
        end
    end

    // only the owner may see ready, and only when a beat can move
    always_comb begin
        w_ready = '0;
        if (w_can) begin
            w_ready[r_gnt] = 1'b1;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.uio_out   = r_uio_out;
    assign bus.uio_oe    = r_uio_oe;
    assign bus.grant_id  = r_gnt;
    assign bus.busy      = (r_state != S_IDLE);

    // grant FSM with registered pad and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_ptr       <= GW'(NREQ - 1);
            r_last_dir  <= 1'b0;
            r_hold      <= '0;
            r_turn      <= '0;
            r_uio_out   <= '0;
            r_uio_oe    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_uio_oe    <= (r_state == S_OWN && bus.ena && r_last_dir)
                         ? 8'hFF : 8'h00;
            if (!bus.ena) begin
                r_state <= S_IDLE;
                r_hold  <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_found) begin
                            r_gnt  <= w_pick;
                            r_turn <= '0;
                            if (bus.req_dir[w_pick] != r_last_dir) begin
                                r_state <= S_TURN;
                            end else begin
                                r_state <= S_OWN;
                            end
                        end
                    end
                    S_TURN: begin
                        if (r_turn == TW'(TURNAROUND - 1)) begin
                            r_state    <= S_OWN;
                            r_last_dir <= w_gdir;
                        end else begin
                            r_turn <= r_turn + 1'b1;
                        end
                    end
                    S_OWN: begin
                        if (w_can) begin
                            if (r_last_dir) begin
                                r_uio_out <= w_gdata;
                            end else begin
                                r_rsp_data         <= bus.uio_in;
                                r_rsp_valid[r_gnt] <= 1'b1;
                            end
                            if (w_glast || w_hold_end) begin
                                r_state <= S_IDLE;
                                r_ptr   <= r_gnt;
                                r_hold  <= '0;
                            end else begin
                                r_hold <= r_hold + 1'b1;
                            end
                        end else begin
                            r_state <= S_IDLE;
                            r_ptr   <= r_gnt;
                            r_hold  <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
